// File: rtl/booth_arb_pkg.sv
// Shared types and sizing helpers for the Booth multiplier arbiter.
package booth_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 31;

  // Watchdog counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after i_ptr wins.
module rr_arbiter import booth_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_k_idx;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_k_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Rotate by ptr with an explicit wrap so non-power-of-two counts work.
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) w_sum = w_sum - (IW+1)'(NUM_REQ);
      w_k_idx = w_sum[IW-1:0];
      if (i_en && !w_found && i_req[w_k_idx]) begin
        w_found        = 1'b1;
        o_gnt[w_k_idx] = 1'b1;
        o_idx          = w_k_idx;
      end
    end
  end
endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one start/done Booth multiplier among NUM_REQ requesters, round-robin,
// with a watchdog that turns a missing done into an error response.
module booth_mul_arbiter import booth_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [15:0]          resp_data,
  output logic                 resp_err,
  output logic                 mul_start,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic                 mul_done,
  input  logic [15:0]          mul_result,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(TIMEOUT);

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_owner;
  logic [CW-1:0] r_cnt;

  logic [NUM_REQ-1:0]      w_gnt;
  logic [IW-1:0]           w_idx;
  logic [NUM_REQ-1:0][7:0] w_a;
  logic [NUM_REQ-1:0][7:0] w_b;
  logic                    w_timeout;
  logic [IW-1:0]           w_next_ptr;

  assign w_a = req_a;
  assign w_b = req_b;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign req_ready  = w_gnt;
  assign mul_start  = (r_state == ISSUE);
  assign busy       = (r_state != IDLE);
  assign w_timeout  = (r_cnt == CW'(TIMEOUT));
  assign w_next_ptr = (r_owner == IW'(NUM_REQ-1)) ? '0 : r_owner + IW'(1);

  always_comb begin
    resp_valid = '0;
    if (r_state == RESP) resp_valid[r_owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (|w_gnt) begin
          mul_a   <= w_a[w_idx];
          mul_b   <= w_b[w_idx];
          r_owner <= w_idx;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        // A done in the same cycle as the timeout still counts as success.
        WAIT: if (mul_done) begin
          resp_data <= mul_result;
          resp_err  <= 1'b0;
          r_state   <= RESP;
        end else if (w_timeout) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
          r_state   <= RESP;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        RESP: if (resp_ready[r_owner]) begin
          r_ptr   <= w_next_ptr;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one 8x8 signed radix-4 Booth multiplier among NUM_REQ requesters. It accepts an operand pair from one requester at a time, starts the multiplier and waits for its done pulse (with a watchdog). It then returns the 16-bit product to the same requester over a valid/ready response channel. It sits between the requester ports and the multiplier's start/done wrapper.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters, 2..8
- TIMEOUT, 31: maximum cycles spent in WAIT before abort, 1..255

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand pair valid
- req_a  in  8*NUM_REQ  multiplicand, signed; requester i at [8i+7:8i]
- req_b  in  8*NUM_REQ  multiplier, signed; same packing
- req_ready  out  NUM_REQ  one-hot or zero; accept strobe
- resp_valid  out  NUM_REQ  one-hot or zero; product available
- resp_ready  in  NUM_REQ  requester consumes response
- resp_data  out  16  signed product; shared by all requesters
- resp_err  out  1  qualifies resp_data: 1 means timeout, resp_data = 0
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_a, mul_b  out  8 each  operands, held stable from mul_start until done
- mul_done  in  1  one-cycle completion pulse
- mul_result  in  16  product, valid in the mul_done cycle
- busy  out  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitrate round-robin over req_valid, starting the search at ptr.
  - The winner w gets req_ready[w]=1 combinationally in the same cycle.
  - On that handshake, capture req_a[w], req_b[w] and owner=w, then go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE:
  - Assert mul_start=1 for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - On mul_done, capture mul_result, set err=0 and go to RESP.
  - If the counter reaches TIMEOUT without mul_done, set err=1, set the product to 0 and go to RESP.
  - mul_done arriving in any state other than WAIT is ignored.
- RESP:
  - Hold resp_valid[owner]=1, with resp_data and resp_err stable, until resp_ready[owner]=1.
  - On that handshake, set ptr = (owner+1) mod NUM_REQ and go to IDLE.
- Fairness: a requester that keeps req_valid asserted is served at most once per NUM_REQ grants.
- req_valid may deassert before it is granted; nothing is captured for that requester.
- The multiplier is treated as opaque; the arbiter does no arithmetic.

## Timing

- Reset values: state=IDLE, ptr=0, all req_ready/resp_valid=0, mul_start=0, mul_a=mul_b=0, resp_data=0, resp_err=0, busy=0.
- Reset is sampled every cycle. Asserting it mid-transaction aborts the transaction with no response, and the requester must reissue.
- Latency from request acceptance (cycle T):
  - mul_start at T+1.
  - Earliest mul_done at T+2, giving resp_valid at T+3.
- Minimum transaction length is 4 cycles for an immediate resp_ready. Back-to-back grants are spaced at least 4 cycles apart.
- Timeout: resp_valid with resp_err=1 appears at T+TIMEOUT+3.
- At most one req_ready bit and at most one resp_valid bit are high in any cycle. Both are never high in the same cycle.

## Structure

- Package booth_arb_pkg holds:
  - the state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - the default NUM_REQ and TIMEOUT constants
  - the helper that computes the counter width as $clog2(TIMEOUT+1).
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req vector, ptr, enable
  - outputs: one-hot grant and encoded index
  - purely combinational.
- The top level holds the FSM, the operand/owner/result registers, the ptr register and the watchdog counter.

## Test plan

- Single request: requester 0 sends a=7, b=-3, and the model returns done after 5 cycles. Expect mul_a=8'h07, mul_b=8'hFD, then resp_valid[0] with resp_data=16'hFFEB, resp_err=0.
- Round-robin: all 4 requesters valid continuously, each with a=i+1, b=10. Expect grant order 0,1,2,3,0 and products 10, 20, 30, 40.
- Backpressure: hold resp_ready low for 6 cycles on a=55, b=20. Expect resp_data=16'h044C held stable, no new req_ready, and ptr advancing only after the handshake.
- Extremes: a=-128, b=-128 gives 16'h4000. a=-128, b=127 gives 16'hC080.
- Timeout: the model never asserts done, with TIMEOUT=31. Expect resp_err=1 and resp_data=0 exactly 34 cycles after acceptance. The next request then completes normally.
- Mid-operation reset: drive rst_n low for 1 cycle during WAIT. All outputs return to reset values the next cycle, a late mul_done is ignored, and arbitration restarts from requester 0.
